// File: rtl/bsg_mcl_axil_tx_arbiter.sv
// Round-robin arbiter that merges host requesters into one AXI-Lite tx word stream,
// locking onto a requester for a whole packet and routing read responses by tag.
module bsg_mcl_axil_tx_arbiter #(
    parameter int num_req_p         = 2,
    parameter int axil_data_width_p = 32,
    parameter int fifo_width_p      = 128,
    parameter int read_credits_p    = 4,
    localparam int ratio_lp = fifo_width_p / axil_data_width_p,
    localparam int id_w     = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int cnt_w    = $clog2(read_credits_p + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_req_p*axil_data_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]                   req_v_i,
    input  logic [num_req_p-1:0]                   req_is_read_i,
    output logic [num_req_p-1:0]                   req_ready_o,
    output logic [axil_data_width_p-1:0]           out_data_o,
    output logic                                   out_v_o,
    input  logic                                   out_ready_i,
    input  logic [axil_data_width_p-1:0]           rsp_data_i,
    input  logic                                   rsp_v_i,
    output logic                                   rsp_ready_o,
    output logic [axil_data_width_p-1:0]           rsp_data_o,
    output logic [num_req_p-1:0]                   rsp_v_o,
    input  logic [num_req_p-1:0]                   rsp_ready_i,
    output logic [id_w-1:0]                        grant_id_o,
    output logic                                   busy_o,
    output logic [cnt_w-1:0]                       reads_outstanding_o,
    output logic                                   err_o
);

    localparam int wc_w  = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
    localparam int ptr_w = (read_credits_p > 1) ? $clog2(read_credits_p) : 1;

    typedef enum logic {IDLE, LOCK} state_e;

    state_e               state_q, state_n;
    logic [id_w-1:0]      rr_ptr_q, rr_ptr_n;
    logic [id_w-1:0]      lock_id_q, lock_id_n;
    logic [wc_w-1:0]      word_cnt_q, word_cnt_n;
    logic [wc_w-1:0]      rsp_cnt_q;
    logic [id_w-1:0]      cand, scan_idx, sel, head;
    logic [num_req_p-1:0] elig;
    logic                 any_elig, tag_full, tag_empty;
    logic                 out_v, xfer, push, pop, rsp_ready, rsp_xfer;

    logic [cnt_w-1:0]     tag_cnt_q;
    logic [ptr_w-1:0]     wr_ptr_q, rd_ptr_q;
    logic [id_w-1:0]      tag_mem [read_credits_p];

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(read_credits_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full is taken from registered occupancy, so a same-cycle pop never unmasks a read.
    assign tag_full  = (tag_cnt_q == cnt_w'(read_credits_p));
    assign tag_empty = (tag_cnt_q == '0);
    assign elig      = req_v_i & ~(req_is_read_i & {num_req_p{tag_full}});

    // Scan from farthest to nearest so the requester right after rr_ptr wins.
    always_comb begin
        cand     = id_w'((int'(rr_ptr_q) + 1) % num_req_p);
        any_elig = 1'b0;
        scan_idx = '0;
        for (int i = num_req_p; i >= 1; i--) begin
            scan_idx = id_w'((int'(rr_ptr_q) + i) % num_req_p);
            if (elig[scan_idx]) begin
                cand     = scan_idx;
                any_elig = 1'b1;
            end
        end
    end

    assign sel        = (state_q == LOCK) ? lock_id_q : cand;
    assign out_v      = reset_n_i & ((state_q == LOCK) ? req_v_i[lock_id_q] : any_elig);
    assign xfer       = out_v & out_ready_i;
    assign out_v_o    = out_v;
    assign out_data_o = req_data_i[int'(sel)*axil_data_width_p +: axil_data_width_p];
    assign grant_id_o = reset_n_i ? sel : '0;
    assign busy_o     = (state_q == LOCK);
    assign push       = xfer & (state_q == IDLE) & req_is_read_i[sel];

    always_comb begin
        req_ready_o      = '0;
        req_ready_o[sel] = xfer;
    end

    always_comb begin
        state_n    = state_q;
        lock_id_n  = lock_id_q;
        word_cnt_n = word_cnt_q;
        rr_ptr_n   = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (ratio_lp > 1) begin
                        state_n    = LOCK;
                        lock_id_n  = sel;
                        word_cnt_n = wc_w'(1);
                    end else begin
                        rr_ptr_n = sel;
                    end
                end
            end
            LOCK: begin
                if (xfer) begin
                    if (word_cnt_q == wc_w'(ratio_lp - 1)) begin
                        state_n    = IDLE;
                        word_cnt_n = '0;
                        rr_ptr_n   = lock_id_q;
                    end else begin
                        word_cnt_n = word_cnt_q + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Response path: the oldest outstanding tag owns the response stream.
    assign head        = tag_mem[rd_ptr_q];
    assign rsp_ready   = reset_n_i & ~tag_empty & rsp_ready_i[head];
    assign rsp_ready_o = rsp_ready;
    assign rsp_xfer    = rsp_v_i & rsp_ready;
    assign pop         = rsp_xfer & (rsp_cnt_q == wc_w'(ratio_lp - 1));
    assign rsp_data_o  = rsp_data_i;
    assign reads_outstanding_o = tag_cnt_q;

    always_comb begin
        rsp_v_o = '0;
        if (reset_n_i && !tag_empty) rsp_v_o[head] = rsp_v_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            lock_id_q  <= '0;
            word_cnt_q <= '0;
            rr_ptr_q   <= id_w'(num_req_p - 1);
            rsp_cnt_q  <= '0;
            tag_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_n;
            lock_id_q  <= lock_id_n;
            word_cnt_q <= word_cnt_n;
            rr_ptr_q   <= rr_ptr_n;
            if (pop)           rsp_cnt_q <= '0;
            else if (rsp_xfer) rsp_cnt_q <= rsp_cnt_q + 1'b1;
            case ({push, pop})
                2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
                2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
                default: tag_cnt_q <= tag_cnt_q;
            endcase
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (rsp_v_i && tag_empty) err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) tag_mem[wr_ptr_q] <= sel;
    end

endmodule

// File: tb/tb_bsg_mcl_axil_tx_arbiter.sv
// Directed self-checking bench for bsg_mcl_axil_tx_arbiter at default parameters
// (2 requesters, 4 words per packet, 4 read credits).
module tb_bsg_mcl_axil_tx_arbiter;

    logic        clk;
    logic        reset_n;
    logic [63:0] req_data;
    logic [1:0]  req_v, req_is_read, req_ready;
    logic [31:0] out_data;
    logic        out_v, out_ready;
    logic [31:0] rsp_data_in, rsp_data_out;
    logic        rsp_v_in, rsp_ready_out;
    logic [1:0]  rsp_v_out, rsp_ready_in;
    logic [0:0]  grant;
    logic        busy;
    logic [2:0]  reads;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] R0_WORD = 32'hAAAA0000;
    localparam logic [31:0] R1_WORD = 32'hBBBB0001;

    bsg_mcl_axil_tx_arbiter dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .req_data_i          (req_data),
        .req_v_i             (req_v),
        .req_is_read_i       (req_is_read),
        .req_ready_o         (req_ready),
        .out_data_o          (out_data),
        .out_v_o             (out_v),
        .out_ready_i         (out_ready),
        .rsp_data_i          (rsp_data_in),
        .rsp_v_i             (rsp_v_in),
        .rsp_ready_o         (rsp_ready_out),
        .rsp_data_o          (rsp_data_out),
        .rsp_v_o             (rsp_v_out),
        .rsp_ready_i         (rsp_ready_in),
        .grant_id_o          (grant),
        .busy_o              (busy),
        .reads_outstanding_o (reads),
        .err_o               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1; outputs are checked at the following negedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_data    = {R1_WORD, R0_WORD};
        req_v       = 2'b00;
        req_is_read = 2'b00;
        out_ready   = 1'b1;
        rsp_data_in = 32'h0;
        rsp_v_in    = 1'b0;
        rsp_ready_in = 2'b11;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_g;
        reset_n = 1'b0;
        clear_inputs();

        // Reset state with both requesters and a response word pending
        req_v    = 2'b11;
        rsp_v_in = 1'b1;
        settle();
        chk("rst_out_v",     out_v, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_ready", rsp_ready_out, 0);
        chk("rst_rsp_v",     rsp_v_out, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_grant",     grant, 0);
        chk("rst_reads",     reads, 0);
        chk("rst_err",       err, 0);
        step();
        do_reset();

        // Two writers with full packets: packets alternate, never interleave
        req_v = 2'b11;
        for (int c = 0; c < 8; c++) begin
            exp_g = (c / 4) % 2;
            settle();
            chk("rr_grant", grant, exp_g);
            chk("rr_ready", req_ready, (exp_g == 0) ? 2'b01 : 2'b10);
            chk("rr_data",  out_data, (exp_g == 0) ? R0_WORD : R1_WORD);
            chk("rr_busy",  busy, (c % 4) != 0);
            step();
        end

        // R0 sends two words, then downstream stalls with R1 still requesting
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("stl_pre_grant", grant, 0);
            step();
        end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("stl_busy",  busy, 1);
            chk("stl_grant", grant, 0);
            chk("stl_ready", req_ready, 2'b00);
            chk("stl_out_v", out_v, 1);
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("stl_tail_ready", req_ready, 2'b01);
            chk("stl_tail_busy",  busy, 1);
            step();
        end
        settle();
        chk("stl_next_grant", grant, 1);
        chk("stl_next_busy",  busy, 0);
        chk("stl_next_data",  out_data, R1_WORD);
        step();

        // Five read packets with no responses: the fifth waits for a tag pop
        do_reset();
        req_v       = 2'b11;
        req_is_read = 2'b11;
        for (int c = 0; c < 16; c++) begin
            exp_g = (c / 4) % 2;
            settle();
            chk("rd_grant", grant, exp_g);
            chk("rd_ready", req_ready, (exp_g == 0) ? 2'b01 : 2'b10);
            chk("rd_reads", reads, (c + 3) / 4);
            step();
        end
        settle();
        chk("rd_full_reads", reads, 4);
        chk("rd_full_out_v", out_v, 0);
        chk("rd_full_ready", req_ready, 2'b00);
        chk("rd_full_grant", grant, 0);
        step();
        rsp_v_in = 1'b1;
        for (int w = 0; w < 4; w++) begin
            settle();
            chk("rd_rsp_v",     rsp_v_out, 2'b01);
            chk("rd_rsp_ready", rsp_ready_out, 1);
            chk("rd_masked",    out_v, 0);
            chk("rd_hold_reads", reads, 4);
            step();
        end
        rsp_ready_in = 2'b00;
        settle();
        chk("rd_pop_reads", reads, 3);
        chk("rd_fifth_ready", req_ready, 2'b01);
        chk("rd_head_r1",   rsp_v_out, 2'b10);
        chk("rd_head_stall", rsp_ready_out, 0);
        step();
        settle();
        chk("rd_refill_reads", reads, 4);
        step();

        // Tags R1 then R0; responses routed in tag order with one stall
        do_reset();
        req_v       = 2'b10;
        req_is_read = 2'b10;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("tag_r1_grant", grant, 1);
            step();
        end
        req_v       = 2'b01;
        req_is_read = 2'b01;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("tag_r0_grant", grant, 0);
            step();
        end
        req_v = 2'b00;
        settle();
        chk("tag_reads", reads, 2);
        step();
        rsp_v_in = 1'b1;
        for (int w = 0; w < 8; w++) begin
            if (w == 1) begin
                rsp_ready_in = 2'b01;
                rsp_data_in  = 32'hDEAD0000;
                settle();
                chk("rsp_stall_ready", rsp_ready_out, 0);
                chk("rsp_stall_v",     rsp_v_out, 2'b10);
                step();
            end
            rsp_ready_in = 2'b11;
            rsp_data_in  = 32'hC0DE0000 + 32'(w);
            settle();
            chk("rsp_v",     rsp_v_out, (w < 4) ? 2'b10 : 2'b01);
            chk("rsp_ready", rsp_ready_out, 1);
            chk("rsp_data",  rsp_data_out, 32'hC0DE0000 + 32'(w));
            step();
        end
        rsp_v_in = 1'b0;
        settle();
        chk("rsp_drained", reads, 0);
        step();

        // Response with no tag outstanding raises a sticky error
        rsp_v_in = 1'b1;
        settle();
        chk("err_ready", rsp_ready_out, 0);
        chk("err_rsp_v", rsp_v_out, 2'b00);
        chk("err_early", err, 0);
        step();
        rsp_v_in = 1'b0;
        settle();
        chk("err_set", err, 1);
        step();
        settle();
        chk("err_sticky", err, 1);
        step();
        reset_n = 1'b0;
        #1;
        chk("err_cleared", err, 0);

        // Reset in the middle of an R1 packet discards it
        do_reset();
        req_v = 2'b10;
        settle();
        chk("mid_grant", grant, 1);
        step();
        settle();
        chk("mid_busy", busy, 1);
        step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_v", out_v, 0);
        chk("mid_rst_ready", req_ready, 2'b00);
        chk("mid_rst_busy",  busy, 0);
        chk("mid_rst_grant", grant, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req_v   = 2'b11;
        settle();
        chk("post_grant", grant, 0);
        chk("post_out_v", out_v, 1);
        chk("post_busy",  busy, 0);
        chk("post_reads", reads, 0);
        chk("post_ready", req_ready, 2'b01);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_mcl_axil_tx_arbiter.md
BSG_MCL_AXIL_TX_ARBITER -- requirements
Module: bsg_mcl_axil_tx_arbiter

Interface
REQ-001 Parameters SHALL be: num_req_p, default 2, number of host requesters (2..4); axil_data_width_p, default 32, word width; fifo_width_p, default 128, packet width; read_credits_p, default 4, tag FIFO depth (max outstanding reads).
REQ-002 Derived: ratio_lp = fifo_width_p/axil_data_width_p words per packet; id_w = max(1, clog2(num_req_p)); cnt_w = clog2(read_credits_p+1).
REQ-003 Ports, in order (name direction width meaning):
- clk_i  in  1  sole clock; all state on rising edge
- reset_n_i  in  1  reset, asynchronous, active-low
- req_data_i  in  num_req_p*axil_data_width_p  per-requester word, requester k at slice k
- req_v_i  in  num_req_p  per-requester word valid
- req_is_read_i  in  num_req_p  packet is remote load; sampled with first word of packet
- req_ready_o  out  num_req_p  per-requester word accepted when v&ready
- out_data_o  out  axil_data_width_p  word toward tx FIFO request path
- out_v_o  out  1  output word valid
- out_ready_i  in  1  downstream ready
- rsp_data_i  in  axil_data_width_p  response word from tx FIFO response path
- rsp_v_i  in  1  response word valid
- rsp_ready_o  out  1  response word consumed when v&ready
- rsp_data_o  out  axil_data_width_p  response word, broadcast to all requesters
- rsp_v_o  out  num_req_p  one-hot response valid to owning requester
- rsp_ready_i  in  num_req_p  per-requester response ready
- grant_id_o  out  id_w  currently selected requester
- busy_o  out  1  packet in progress (LOCK state)
- reads_outstanding_o  out  cnt_w  tag FIFO occupancy
- err_o  out  1  sticky protocol error

Function
REQ-004 Request FSM SHALL have states IDLE and LOCK.
REQ-005 In IDLE, eligible(k) = req_v_i[k] & ~(req_is_read_i[k] & tag_full); selection SHALL be round-robin starting at rr_ptr+1 mod num_req_p, wrapping.
REQ-006 Datapath: out_v_o = req_v_i[sel] & eligible-or-locked; out_data_o = req_data_i[sel]; req_ready_o[sel] = out_ready_i & out_v_o; all other req_ready_o bits 0; zero added latency (combinational pass-through).
REQ-007 On first-word transfer in IDLE with ratio_lp>1: enter LOCK, latch lock_id=sel, word_cnt=1; with ratio_lp==1 the SHALL remain IDLE and update rr_ptr=sel.
REQ-008 In LOCK only lock_id SHALL be selected, regardless of other req_v_i; word_cnt increments per transfer; transfer at word_cnt==ratio_lp-1 SHALL return to IDLE, reset word_cnt to 0, set rr_ptr=lock_id.
REQ-009 Stall (out_ready_i=0 or req_v_i[lock_id]=0) in LOCK SHALL hold state, word_cnt and lock_id.
REQ-010 First-word transfer with req_is_read_i[sel]=1 SHALL push sel into the tag FIFO; read packets SHALL be masked in IDLE while tag FIFO full, even if a pop occurs that cycle (no bypass).
REQ-011 Response: when tag FIFO non-empty, head tag h: rsp_v_o[h]=rsp_v_i, rsp_ready_o=rsp_ready_i[h]; other rsp_v_o bits 0.
REQ-012 Response word counter SHALL count transfers; on transfer ratio_lp-1 it SHALL pop the tag FIFO and clear to 0.
REQ-013 Tag FIFO empty: rsp_ready_o=0, rsp_v_o=0; rsp_v_i=1 in that state SHALL set err_o, held until reset.
REQ-014 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; reads_outstanding_o SHALL equal occupancy.
REQ-015 grant_id_o = lock_id in LOCK, else round-robin candidate (rr_ptr+1 when none eligible); busy_o=1 exactly in LOCK.

Reset
REQ-016 reset_n_i low SHALL asynchronously force: IDLE, word counters 0, rr_ptr=num_req_p-1 (requester 0 first), tag FIFO empty, err_o=0, busy_o=0, grant_id_o=0.
REQ-017 While reset_n_i low, out_v_o, req_ready_o, rsp_ready_o and rsp_v_o SHALL be 0; a packet in progress SHALL be discarded with no partial resumption.

Verification
REQ-018 Defaults, both requesters hold 4-word writes, out_ready_i=1 -> words R0w0..w3, R1w0..w3, R0w0..; no interleave within a packet.
REQ-019 R0 mid-packet after 2 words, out_ready_i=0 for 3 cycles with R1 valid -> busy_o=1, grant_id_o=0, then R0 words 2,3 complete before R1 starts.
REQ-020 Five read packets (R0,R1,R0,R1,R0) with no responses -> four accepted, reads_outstanding_o=4, fifth held (req_ready_o=0) until 4 response words pop one tag.
REQ-021 Two outstanding tags (R1 then R0), 8 response words -> words 0-3 on rsp_v_o=2'b10, words 4-7 on 2'b01; rsp_ready_i[1]=0 stalls rsp_ready_o.
REQ-022 rsp_v_i=1 with empty tag FIFO -> rsp_ready_o=0, err_o=1 next cycle and sticky until reset.
REQ-023 reset_n_i asserted after word 1 of R1 packet -> outputs 0 immediately; after release R0 granted first, occupancy 0.
